key_onehot_arbiter: RTL and testbench

//  Upstream stage of the 4-to-2 encoder: turns four raw push-button inputs into clean one-hot press events.

---
 rtl/key_onehot_arbiter_if.sv | 25 ++
 rtl/key_onehot_arbiter.sv | 140 ++++++++++++++
 tb/tb_key_onehot_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_onehot_arbiter_if.sv
// Key-event handshake bundle: raw keys and ack into the arbiter, one-hot event, valid and overrun out.
// The master modport is the arbiter side; the slave modport is the stimulus/consumer side.
interface key_onehot_arbiter_if;
    logic [3:0] key_in;
    logic       ack;
    logic [3:0] onehot;
    logic       valid;
    logic       overrun;

    modport master (
        input  key_in,
        input  ack,
        output onehot,
        output valid,
        output overrun
    );

    modport slave (
        output key_in,
        output ack,
        input  onehot,
        input  valid,
        input  overrun
    );
endinterface

// File: rtl/key_onehot_arbiter.sv
// Purpose: sync + debounce four keys, queue presses, present one at a time as a one-hot event.
// Latency: valid rises DEB_CYCLES+4 edges after a stable key change on an idle block.
// Backpressure: an event holds until ack; presses meanwhile queue (re-press of a queued key pulses overrun).
// Define KEY_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, key 0 highest.
module key_onehot_arbiter #(
    parameter int DEB_CYCLES = 16,
    parameter int DEB_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    key_onehot_arbiter_if.master bus
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       deb;
    logic [3:0]       deb_q;
    logic [DEB_W-1:0] cnt [4];
    logic [3:0]       pend;
    logic [3:0]       press;
    logic [3:0]       grant;
    logic [3:0]       pend_nxt;
    logic [1:0]       gidx;
    logic             grant_en;
    state_t           state;
    logic [3:0]       onehot_r;
    logic             valid_r;
    logic             overrun_r;

    // Synchroniser and per-key debounce: a level change needs DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            s1    <= bus.key_in;
            s2    <= s1;
            deb_q <= deb;
            for (int k = 0; k < 4; k++) begin
                if (s2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == DEB_LAST) begin
                    deb[k] <= s2[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    assign press = deb & ~deb_q;

`ifdef KEY_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;

    // ptr holds the last granted key; the search starts just after it, so ptr itself ranks last.
    always_comb begin
        gidx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (pend[ptr + 2'(i)]) begin
                gidx = ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (grant_en) begin
            ptr <= gidx;
        end
    end
`else
    always_comb begin
        gidx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                gidx = 2'(i);
            end
        end
    end
`endif

    assign grant_en = (state == IDLE) && (pend != 4'b0000);
    assign grant    = grant_en ? (4'b0001 << gidx) : 4'b0000;
    // A new press on the key being granted this cycle survives the clear.
    assign pend_nxt = (pend & ~grant) | press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            onehot_r  <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            overrun_r <= |(press & pend);
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        onehot_r <= grant;
                        valid_r  <= 1'b1;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack) begin
                        onehot_r <= '0;
                        valid_r  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    onehot_r <= '0;
                    valid_r  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.onehot  = onehot_r;
    assign bus.valid   = valid_r;
    assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_key_onehot_arbiter.sv
// Bench for key_onehot_arbiter (DEB_CYCLES=4): directed table and sequences, then random keys/ack/reset
// compared every cycle against a sample-window reference model.
module tb_key_onehot_arbiter;

    localparam int DEB = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic chk_en;

    key_onehot_arbiter_if bus ();

    key_onehot_arbiter #(.DEB_CYCLES(DEB), .DEB_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: a key's debounced level flips when every raw sample in the window
    // (taken 2..DEB+1 edges ago) differs from it; a rise becomes a press one edge later.
    logic [3:0] mh [0:DEB];
    logic [3:0] mdeb;
    logic [3:0] mrise;
    logic [3:0] mpend;
    logic [3:0] mpress;
    logic       movr;
    logic       all_diff;
    int         mcur;
    int         mlast;
    int         mg;

    function automatic int pick(input logic [3:0] p, input int last);
        int idx;
        for (int i = 0; i < 4; i++) begin
`ifdef KEY_ARB_ROUND_ROBIN_EN
            idx = (last + 1 + i) % 4;
`else
            idx = i;
`endif
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= DEB; j++) mh[j] = 4'b0000;
            mdeb  = 4'b0000;
            mrise = 4'b0000;
            mpend = 4'b0000;
            movr  = 1'b0;
            mcur  = -1;
            mlast = 0;
        end else begin
            mpress = mrise;
            movr   = |(mpress & mpend);
            if (mcur >= 0) begin
                if (bus.ack) mcur = -1;
            end else if (mpend != 4'b0000) begin
                mg        = pick(mpend, mlast);
                mcur      = mg;
                mlast     = mg;
                mpend[mg] = 1'b0;
            end
            mpend = mpend | mpress;
            mrise = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DEB; j++) begin
                    if (mh[j][k] == mdeb[k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    mdeb[k] = ~mdeb[k];
                    if (mdeb[k]) mrise[k] = 1'b1;
                end
            end
            for (int j = DEB; j >= 1; j--) mh[j] = mh[j-1];
            mh[0] = bus.key_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_onehot", bus.onehot, (mcur >= 0) ? (32'd1 << mcur) : 32'd0);
            chk("model_valid", bus.valid, (mcur >= 0) ? 32'd1 : 32'd0);
            chk("model_overrun", bus.overrun, movr);
        end
    end

    typedef struct {
        logic [3:0] key;
        logic       ack;
        int         cycles;
        logic [3:0] exp_oh;
        logic       exp_vld;
    } vec_t;

    vec_t       tbl [6];
    logic [3:0] first_g;
    logic [3:0] second_g;
    int         seen;
    int         ovr_cnt;
    int         k0_cnt;

    initial begin
        // Single press of key 2, held, acknowledged, then released.
        tbl[0] = '{4'b0100, 1'b0, 7, 4'b0000, 1'b0};
        tbl[1] = '{4'b0100, 1'b0, 1, 4'b0100, 1'b1};
        tbl[2] = '{4'b0100, 1'b0, 2, 4'b0100, 1'b1};
        tbl[3] = '{4'b0000, 1'b0, 3, 4'b0100, 1'b1};
        tbl[4] = '{4'b0000, 1'b1, 1, 4'b0000, 1'b0};
        tbl[5] = '{4'b0000, 1'b0, 10, 4'b0000, 1'b0};
`ifdef KEY_ARB_ROUND_ROBIN_EN
        first_g  = 4'b1000;
        second_g = 4'b0010;
`else
        first_g  = 4'b0010;
        second_g = 4'b1000;
`endif
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        rst         = 1'b1;
        bus.key_in  = 4'b0000;
        bus.ack     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_onehot", bus.onehot, 0);
        chk("reset_valid", bus.valid, 0);
        chk("reset_overrun", bus.overrun, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            bus.key_in = tbl[i].key;
            bus.ack    = tbl[i].ack;
            cyc(tbl[i].cycles);
            chk($sformatf("tbl%0d_onehot", i), bus.onehot, tbl[i].exp_oh);
            chk($sformatf("tbl%0d_valid", i), bus.valid, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_overrun", i), bus.overrun, 0);
        end

        // Bounce on key 1: never stable long enough to register.
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            bus.key_in = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            repeat (2) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.valid) seen++;
            end
        end
        bus.key_in = 4'b0000;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid) seen++;
        end
        chk("bounce_no_valid", seen, 0);

        // Key 1 grant first, so the round-robin pointer sits at 1.
        bus.key_in = 4'b0010;
        bus.ack    = 1'b1;
        cyc(8);
        chk("key1_grant", bus.onehot, 4'b0010);
        cyc(1);
        chk("key1_acked", bus.valid, 0);
        bus.key_in = 4'b0000;
        cyc(12);

        // Simultaneous press of keys 1 and 3 with ack held.
        bus.key_in = 4'b1010;
        cyc(8);
        chk("simul_first", bus.onehot, first_g);
        cyc(1);
        chk("simul_gap", bus.valid, 0);
        cyc(1);
        chk("simul_second", bus.onehot, second_g);
        cyc(1);
        chk("simul_done", bus.valid, 0);
        bus.key_in = 4'b0000;
        bus.ack    = 1'b0;
        cyc(12);

        // Overrun: key 0 queued behind key 2, released and re-pressed while still queued.
        bus.key_in = 4'b0100;
        cyc(10);
        chk("ovr_key2_up", bus.onehot, 4'b0100);
        bus.key_in = 4'b0101;
        cyc(10);
        bus.key_in = 4'b0100;
        cyc(8);
        bus.key_in = 4'b0101;
        ovr_cnt    = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.overrun) ovr_cnt++;
        end
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_key2_held", bus.onehot, 4'b0100);
        bus.ack = 1'b1;
        k0_cnt  = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.onehot == 4'b0001) k0_cnt++;
        end
        chk("ovr_key0_once", k0_cnt, 1);
        bus.ack    = 1'b0;
        bus.key_in = 4'b0000;
        cyc(12);

        // Reset mid-operation with an event presented and keys 0,1 pending.
        bus.key_in = 4'b0100;
        cyc(10);
        chk("midrst_valid_before", bus.valid, 1);
        bus.key_in = 4'b0111;
        cyc(10);
        @(posedge clk);
        #2;
        rst        = 1'b1;
        bus.key_in = 4'b0000;
        #1;
        chk("midrst_async_onehot", bus.onehot, 0);
        chk("midrst_async_valid", bus.valid, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid) seen++;
        end
        chk("midrst_no_events", seen, 0);

        // Key 0 held through reset re-registers after release.
        @(posedge clk);
        #2;
        rst        = 1'b1;
        bus.key_in = 4'b0001;
        cyc(3);
        rst = 1'b0;
        cyc(7);
        chk("held_edge7_valid", bus.valid, 0);
        cyc(1);
        chk("held_edge8_valid", bus.valid, 1);
        chk("held_edge8_onehot", bus.onehot, 4'b0001);
        bus.ack = 1'b1;
        cyc(1);
        chk("held_acked", bus.valid, 0);
        bus.ack    = 1'b0;
        bus.key_in = 4'b0000;
        cyc(12);

        // Random keys, ack and occasional reset pulses against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) bus.key_in[k] = ~bus.key_in[k];
            end
            bus.ack = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
